fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin burst arbiter that shares the single write port of the team's FIFO among NREQ requesters.
- Grants one requester at a time and holds the grant for a whole burst.
- Forwards that requester's data into the FIFO and stalls on fifo_full.
- Sits between the producer blocks and the FIFO write side, in the write clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- wsize, 8, data width; matches the FIFO wsize.
- MAX_BURST, 8, maximum beats per grant (power of 2, 2..256).

Ports:
- clk  input  1  write-side clock; all logic rises on posedge clk.
- rst  input  1  asynchronous active-high reset.
- req  input  NREQ  per-requester request; held high while data is valid.
- in_data  input  NREQ*wsize  requester i data at bits [i*wsize +: wsize].
- in_last  input  NREQ  per-requester last-beat flag, sampled with its data.
- ack  output  NREQ  one-hot beat-accepted strobe to the requester.
- gnt  output  NREQ  one-hot registered grant.
- fifo_we  output  1  FIFO write enable.
- fifo_wdata  output  wsize  FIFO write data.
- fifo_full  input  1  FIFO full flag.
- abort  output  1  one-cycle pulse when a granted requester drops req before its burst ends.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, beat count=0, abort=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - ack, fifo_we and fifo_wdata read 0.
  - Reset mid-burst discards the burst with no write; the in-flight beat is not acked.
- States:
  - IDLE: if any req is high, pick the first requester scanning from last+1 modulo NREQ upward. Register gnt to that one-hot, set last to the winner, count=0, go to BURST. If no req, stay in IDLE with gnt=0.
  - BURST, beat: xfer = req[g] && !fifo_full.
    - fifo_we=xfer and ack[g]=xfer, both combinational in the same cycle.
    - fifo_wdata=in_data slice g, muxed combinationally; 0 when gnt=0.
    - Each xfer increments count.
  - BURST, termination: on an xfer with in_last[g]=1, or count==MAX_BURST-1, go to IDLE, gnt<=0, count<=0. Both conditions together give a single termination, with no extra beat.
  - BURST, request dropped: req[g]=0 while no termination has occurred gives abort=1 for one cycle (registered, asserted the cycle after detection), go to IDLE, gnt<=0.
- fifo_full in BURST: no xfer, no ack, count holds, grant holds indefinitely. No timeout.
- Latency:
  - req rising in IDLE at cycle 0 gives gnt at cycle 1 and first possible write at cycle 1.
  - After a burst ends there is exactly one IDLE cycle before the next grant.
- Fairness: a requester that just finished has lowest priority in the next arbitration.
- Count width: $clog2(MAX_BURST); count wraps to 0 at termination only.
- Invariants:
  - gnt has at most one bit set.
  - ack is a subset of gnt.
  - fifo_we is 0 whenever fifo_full=1.
  - No writes in IDLE.
- Requester signals other than the granted one are ignored. Their req may change freely.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO_EN.
- Defined:
  - Requester 0 is strict high priority: in IDLE, req[0]=1 always wins.
  - Requesters 1..NREQ-1 round-robin among themselves only when req[0]=0.
  - The pointer is updated only by wins of requesters 1..NREQ-1.
  - Bursts are never pre-empted.
- Not defined: pure round-robin over all NREQ as described above.

Test Plan:
- Reset then single request:
  - Stimulus: rst pulse; req=4'b0010; in_data[1] = 8'hA0, A1, A2 over successive accepted beats; in_last on the third beat; fifo_full=0.
  - Response: gnt=4'b0010 at cycle 1; fifo_we high cycles 1-3; fifo_wdata A0, A1, A2; ack[1] each beat; gnt=0 at cycle 4.
- All requesters, continuous traffic:
  - Stimulus: req=4'b1111 held; each burst is 2 beats.
  - Response: grant order 0,1,2,3,0; one IDLE gap between bursts; 8 writes in 12 cycles.
- MAX_BURST limit:
  - Stimulus: req[2] held with in_last=0, MAX_BURST=8.
  - Response: exactly 8 writes; then IDLE; then re-grant to 2 only if it is the sole requester.
- Full stall:
  - Stimulus: fifo_full=1 for cycles 2-5 during a 4-beat burst.
  - Response: fifo_we=0 and ack=0 in cycles 2-5; count frozen; all 4 beats written in order after release.
- Abort and async reset:
  - Stimulus (abort): req[3] drops after beat 1.
  - Response (abort): abort=1 for one cycle; gnt=0; next requester granted.
  - Stimulus (reset): rst asserted mid-burst, asynchronously.
  - Response (reset): gnt, fifo_we and ack go 0 immediately.
- Priority build:
  - Stimulus: FIFO_WR_ARB_PRIO_EN defined; req=4'b1110 then req[0] rises.
  - Response: requester 0 wins the next IDLE arbitration over 2 and 3.
  - Stimulus: same with the macro undefined.
  - Response: round-robin order.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; FIFO_WR_ARB_PRIO_EN makes requester 0 strict-priority.
// Latency: grant one cycle after req in IDLE, writes start in the grant cycle, one IDLE cycle between bursts.
// Backpressure: fifo_full stalls the beat (no ack, no write) and the grant is held indefinitely.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int wsize     = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*wsize-1:0] in_data,
    input  logic [NREQ-1:0]       in_last,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       gnt,
    output logic                  fifo_we,
    output logic [wsize-1:0]      fifo_wdata,
    input  logic                  fifo_full,
    output logic                  abort
);

    localparam int CW = $clog2(MAX_BURST);
    localparam int LW = $clog2(NREQ);

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [LW-1:0]   last_q;
    logic [CW-1:0]   cnt_q;
    logic            abort_q;

    logic            req_g;
    logic            last_g;
    logic            xfer;
    logic            term;
    logic            win_vld;
    logic [LW-1:0]   win_idx;
    logic [NREQ-1:0] rr_req;
    logic [LW-1:0]   scan_idx;

    assign gnt   = gnt_q;
    assign abort = abort_q;

    // Datapath for the granted requester only; everyone else is ignored.
    always_comb begin
        req_g  = |(req & gnt_q);
        last_g = |(in_last & gnt_q);
        xfer   = (state_q == BURST) && req_g && !fifo_full;
        term   = xfer && (last_g || (cnt_q == CW'(MAX_BURST - 1)));
        ack    = xfer ? gnt_q : '0;
        fifo_we = xfer;
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) fifo_wdata = in_data[i*wsize +: wsize];
        end
    end

    // Scan upward from last+1 so the most recent winner has lowest priority.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        rr_req   = req;
`ifdef FIFO_WR_ARB_PRIO_EN
        rr_req[0] = 1'b0;
        if (req[0]) begin
            win_vld = 1'b1;
        end
`endif
        for (int off = 1; off <= NREQ; off++) begin
            scan_idx = LW'((int'(last_q) + off) % NREQ);
            if (!win_vld && rr_req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NREQ - 1);
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (win_vld) begin
                        gnt_q   <= NREQ'(1) << win_idx;
                        state_q <= BURST;
`ifdef FIFO_WR_ARB_PRIO_EN
                        // Strict-priority wins leave the round-robin pointer alone.
                        if (win_idx != '0) last_q <= win_idx;
`else
                        last_q <= win_idx;
`endif
                    end else begin
                        gnt_q <= '0;
                    end
                end
                BURST: begin
                    if (!req_g) begin
                        abort_q <= 1'b1;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (term) begin
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
